// File: rtl/sigma_gpio_pkg.sv
// Shared constants, decoded-request struct and byte-enable helpers for the
// sigma_gpio peripheral.
package sigma_gpio_pkg;

  localparam logic [31:0] GPIO_OUT       = 32'h0;
  localparam logic [31:0] GPIO_IN        = 32'h4;
  localparam logic [31:0] GPIO_IRQEN     = 32'h8;
  localparam logic [31:0] GPIO_STATUS    = 32'hC;
  localparam int unsigned GPIO_CH_STRIDE = 16;

  typedef struct packed {
    logic       hit;
    logic [2:0] ch;
    logic [3:0] reg_off;
  } gpio_dec_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    return (old & ~be_mask(be)) | (wdata & be_mask(be));
  endfunction

endpackage

// File: rtl/sigma_gpio_if.sv
// Split-transaction tile bus as seen by a peripheral.
interface sigma_gpio_if;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [3:0]  bus_be_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    output bus_ack_o, bus_resp_o, bus_rdata_bo
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain followed by a history flop for rising-edge pulses.
module gpio_sync_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o
);

  // Stage 0 samples the raw pin; stage SYNC_STAGES-1 is the usable value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/sigma_gpio.sv
// Memory-mapped GPIO: NCH channels of OUT / IN / IRQ_EN / STATUS registers
// with rising-edge capture and a registered combined interrupt.
module sigma_gpio
  import sigma_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NCH         = 2,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  sigma_gpio_if.slave       bus,
  input  logic [NCH*32-1:0] gpio_bi,
  output logic [NCH*32-1:0] gpio_bo,
  output logic              irq_o
);

  localparam logic [31:0] SPAN = 32'(NCH * GPIO_CH_STRIDE);

  logic [31:0] off;
  gpio_dec_t   dec;
  logic        wr, rd;

  // Unsigned 32-bit subtraction: addresses below BASE_ADDR wrap high and miss.
  assign off         = bus.bus_addr_bi - BASE_ADDR;
  assign dec.hit     = off < SPAN;
  assign dec.ch      = off[6:4];
  assign dec.reg_off = {off[3:2], 2'b00};

  assign bus.bus_ack_o = bus.bus_req_i;
  assign wr = bus.bus_req_i &  bus.bus_we_i & dec.hit;
  assign rd = bus.bus_req_i & ~bus.bus_we_i;

  logic [NCH-1:0][31:0] out_q, irqen_q, status_q, in_w, rise_w, rd_ch;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic        ch_sel, ch_wr;
    logic [31:0] clr;

    gpio_sync_edge #(.WIDTH(32), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .d_i      (gpio_bi[32*k +: 32]),
      .q_o      (in_w[k]),
      .rise_o   (rise_w[k])
    );

    assign ch_sel = dec.hit && (dec.ch == 3'(k));
    assign ch_wr  = wr && (dec.ch == 3'(k));
    assign clr    = (ch_wr && dec.reg_off == GPIO_STATUS[3:0])
                    ? (bus.bus_wdata_bi & be_mask(bus.bus_be_bi)) : '0;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        out_q[k]    <= '0;
        irqen_q[k]  <= '0;
        status_q[k] <= '0;
      end else begin
        if (ch_wr && dec.reg_off == GPIO_OUT[3:0])
          out_q[k] <= be_merge(out_q[k], bus.bus_wdata_bi, bus.bus_be_bi);
        if (ch_wr && dec.reg_off == GPIO_IRQEN[3:0])
          irqen_q[k] <= be_merge(irqen_q[k], bus.bus_wdata_bi, bus.bus_be_bi);
        // A fresh edge beats a simultaneous write-1-to-clear.
        status_q[k] <= (status_q[k] & ~clr) | rise_w[k];
      end
    end

    always_comb begin
      rd_ch[k] = '0;
      if (ch_sel) begin
        case (dec.reg_off)
          GPIO_OUT[3:0]:    rd_ch[k] = out_q[k];
          GPIO_IN[3:0]:     rd_ch[k] = in_w[k];
          GPIO_IRQEN[3:0]:  rd_ch[k] = irqen_q[k];
          GPIO_STATUS[3:0]: rd_ch[k] = status_q[k];
          default:          rd_ch[k] = '0;
        endcase
      end
    end
  end

  logic [31:0] rdata_d;
  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NCH; k++) rdata_d |= rd_ch[k];
  end

  logic        resp_q, irq_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      resp_q  <= rd;
      rdata_q <= rd ? rdata_d : '0;
      irq_q   <= |(status_q & irqen_q);
    end
  end

  assign bus.bus_resp_o   = resp_q;
  assign bus.bus_rdata_bo = rdata_q;
  assign gpio_bo          = out_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_sigma_gpio.sv
// Directed-vector bench for sigma_gpio (NCH=2, SYNC_STAGES=2).
module tb_sigma_gpio;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic [63:0] gpio_bi, gpio_bo;
  logic        irq_o;
  int          n_vec = 0;
  int          n_err = 0;

  sigma_gpio_if bus ();

  sigma_gpio #(.BASE_ADDR(32'h8000_0000), .NCH(2), .SYNC_STAGES(2)) dut (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .bus      (bus),
    .gpio_bi  (gpio_bi),
    .gpio_bo  (gpio_bo),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.bus_req_i = 1'b1; bus.bus_we_i = 1'b1;
    bus.bus_addr_bi = a; bus.bus_wdata_bi = d; bus.bus_be_bi = be;
    @(negedge clk_i);
    bus.bus_req_i = 1'b0; bus.bus_we_i = 1'b0;
    chk_vec("wr_no_resp", 32'(bus.bus_resp_o), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.bus_req_i = 1'b1; bus.bus_we_i = 1'b0; bus.bus_addr_bi = a;
    chk_vec({tag, "_ack"}, 32'(bus.bus_ack_o), 32'd1);
    @(negedge clk_i);
    bus.bus_req_i = 1'b0;
    chk_vec({tag, "_resp"}, 32'(bus.bus_resp_o), 32'd1);
    chk_vec({tag, "_data"}, bus.bus_rdata_bo, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    arst_n_i = 1'b0;
    gpio_bi  = '0;
    bus.bus_req_i = 1'b0; bus.bus_we_i = 1'b0;
    bus.bus_addr_bi = '0; bus.bus_be_bi = '0; bus.bus_wdata_bi = '0;
    idle(2);
    chk_vec("rst_gpio_lo", gpio_bo[31:0], 32'h0);
    chk_vec("rst_gpio_hi", gpio_bo[63:32], 32'h0);
    chk_vec("rst_resp", 32'(bus.bus_resp_o), 32'd0);
    chk_vec("rst_rdata", bus.bus_rdata_bo, 32'h0);
    chk_vec("rst_irq", 32'(irq_o), 32'd0);
    arst_n_i = 1'b1;
    idle(1);

    // Byte-enabled write to channel 1 OUT, then one-cycle read response.
    do_write(32'h8000_0010, 32'hA5A5_A5A5, 4'b0011);
    chk_vec("out1_bo", gpio_bo[63:32], 32'h0000_A5A5);
    chk_vec("out0_bo", gpio_bo[31:0], 32'h0);
    do_read("rd_out1", 32'h8000_0010, 32'h0000_A5A5);
    idle(1);
    chk_vec("resp_one_shot", 32'(bus.bus_resp_o), 32'd0);
    chk_vec("rdata_idle_zero", bus.bus_rdata_bo, 32'h0);

    // Input sync latency and edge capture.
    gpio_bi[3:0] = 4'h5;
    do_read("rd_in_early", 32'h8000_0004, 32'h0);
    idle(2);
    do_read("rd_in", 32'h8000_0004, 32'h5);
    do_read("rd_stat", 32'h8000_000C, 32'h5);
    chk_vec("irq_masked", 32'(irq_o), 32'd0);
    do_write(32'h8000_0008, 32'h1, 4'hF);
    chk_vec("irq_lag", 32'(irq_o), 32'd0);
    idle(1);
    chk_vec("irq_rise", 32'(irq_o), 32'd1);

    // W1C of bit0, irq falls one cycle later.
    do_write(32'h8000_000C, 32'h1, 4'hF);
    chk_vec("irq_hold", 32'(irq_o), 32'd1);
    idle(1);
    chk_vec("irq_fall", 32'(irq_o), 32'd0);
    do_read("rd_stat_w1c", 32'h8000_000C, 32'h4);

    // Falling edge does not set STATUS; rising edge colliding with W1C wins.
    gpio_bi[0] = 1'b0;
    idle(3);
    do_read("rd_stat_fall", 32'h8000_000C, 32'h4);
    gpio_bi[0] = 1'b1;
    idle(2);
    do_write(32'h8000_000C, 32'h1, 4'hF);
    do_read("rd_stat_setwin", 32'h8000_000C, 32'h5);
    chk_vec("irq_setwin", 32'(irq_o), 32'd1);

    // Unmapped reads, ignored writes.
    do_read("rd_unmap_hi", 32'h8000_0020, 32'h0);
    do_read("rd_unmap_lo", 32'h7FFF_FFFC, 32'h0);
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h8000_0004, 32'hFFFF_FFFF, 4'hF);
    chk_vec("ign_gpio_hi", gpio_bo[63:32], 32'h0000_A5A5);
    chk_vec("ign_gpio_lo", gpio_bo[31:0], 32'h0);
    do_read("rd_in_ign", 32'h8000_0004, 32'h5);
    do_write(32'h8000_0000, 32'h1234_5678, 4'b1100);
    chk_vec("out0_be", gpio_bo[31:0], 32'h1234_0000);

    // Back-to-back reads, then with a write interleaved.
    do_read("b2b_0", 32'h8000_0000, 32'h1234_0000);
    do_read("b2b_1", 32'h8000_0004, 32'h5);
    do_read("b2b_2", 32'h8000_000C, 32'h5);
    do_read("mix_0", 32'h8000_0008, 32'h1);
    do_write(32'h8000_0000, 32'h0000_00AB, 4'b0001);
    do_read("mix_1", 32'h8000_0000, 32'h1234_00AB);

    // Reset right after a read is accepted: response dropped, outputs cleared.
    gpio_bi = '0;
    bus.bus_req_i = 1'b1; bus.bus_we_i = 1'b0; bus.bus_addr_bi = 32'h8000_0000;
    @(posedge clk_i);
    #1;
    arst_n_i = 1'b0;
    bus.bus_req_i = 1'b0;
    #1;
    chk_vec("arst_resp", 32'(bus.bus_resp_o), 32'd0);
    chk_vec("arst_rdata", bus.bus_rdata_bo, 32'h0);
    chk_vec("arst_gpio_lo", gpio_bo[31:0], 32'h0);
    chk_vec("arst_gpio_hi", gpio_bo[63:32], 32'h0);
    chk_vec("arst_irq", 32'(irq_o), 32'd0);
    idle(2);
    arst_n_i = 1'b1;
    idle(1);
    chk_vec("post_rst_resp", 32'(bus.bus_resp_o), 32'd0);
    do_read("post_out0", 32'h8000_0000, 32'h0);
    do_read("post_out1", 32'h8000_0010, 32'h0);
    do_read("post_stat", 32'h8000_000C, 32'h0);
    do_read("post_irqen", 32'h8000_0008, 32'h0);
    idle(1);
    chk_vec("post_irq", 32'(irq_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
